conv_out_collector: RTL and testbench

//  Drain side of the conv line-buffer path. Accepts one raw conv result per input pixel, in raster order,

---
 rtl/cnn_pkg.sv | 18 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/conv_out_collector.sv | 109 ++++++++++
 tb/tb_conv_out_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared defaults and beat layout for the conv line-buffer path.
// Both the sliding-window side and the output collector import this package.
package cnn_pkg;
    localparam int DEFAULT_ACC_WIDTH  = 20;
    localparam int DEFAULT_WORD_SIZE  = 8;
    localparam int DEFAULT_ROW_SIZE   = 10;
    localparam int DEFAULT_IMG_ROWS   = 10;
    localparam int DEFAULT_KERNEL     = 3;
    localparam int DEFAULT_SHIFT      = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [DEFAULT_WORD_SIZE-1:0] data;
        logic                         sof;
        logic                         eol;
        logic                         eof;
    } out_beat_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: RAM array with a registered head word and write-through
// bypass when the word being written becomes the new head.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire, empty_d, head_bypass;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = rd_data_q;

    assign wr_fire     = wr_en_i && !full_o;
    assign rd_fire     = rd_en_i && !empty_o;
    assign wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_fire);
    assign rd_ptr_d    = rd_ptr_q + (AW+1)'(rd_fire);
    assign empty_d     = (wr_ptr_d == rd_ptr_d);
    assign head_bypass = wr_fire && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Head only reloads when something remains, so outputs hold their last value when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (!empty_d) begin
                rd_data_q <= head_bypass ? wr_data_i : mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/conv_out_collector.sv
// Drain side of the conv path: tracks input raster position, keeps only full-window results,
// requantises them and streams the output feature map with sof/eol/eof framing.
module conv_out_collector
    import cnn_pkg::*;
#(
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int ROW_SIZE   = DEFAULT_ROW_SIZE,
    parameter int IMG_ROWS   = DEFAULT_IMG_ROWS,
    parameter int KERNEL     = DEFAULT_KERNEL,
    parameter int SHIFT      = DEFAULT_SHIFT,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACC_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 frame_done
);
    localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int BW = WORD_SIZE + 3;

    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(ROW_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_ROWS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << WORD_SIZE) - 1);

    // Arithmetic shift rounds toward -inf, then clamp into the unsigned output range.
    function automatic logic [WORD_SIZE-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] v;
        v = acc >>> SHIFT;
        if (v[ACC_WIDTH-1]) begin
            return '0;
        end else if (v > SAT_MAX) begin
            return '1;
        end
        return v[WORD_SIZE-1:0];
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          frame_done_q;
    logic          fifo_full, fifo_empty;
    logic          in_xfer, keep, beat_sof, beat_eol, beat_eof;
    logic [BW-1:0] wr_beat, rd_beat;

    assign in_ready = !fifo_full;
    assign in_xfer  = in_valid && in_ready;
    assign keep     = (col_q >= COL_FIRST) && (row_q >= ROW_FIRST);
    assign beat_sof = (col_q == COL_FIRST) && (row_q == ROW_FIRST);
    assign beat_eol = (col_q == COL_LAST);
    assign beat_eof = beat_eol && (row_q == ROW_LAST);
    assign wr_beat  = {requant(in_data), beat_sof, beat_eol, beat_eof};

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= out_valid && out_ready && out_eof;
        end
    end

    sync_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (in_xfer && keep),
        .wr_data_i (wr_beat),
        .full_o    (fifo_full),
        .rd_en_i   (out_ready),
        .rd_data_o (rd_beat),
        .empty_o   (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = rd_beat[BW-1:3];
    assign out_sof    = rd_beat[2];
    assign out_eol    = rd_beat[1];
    assign out_eof    = rd_beat[0];
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: default geometry plus a K=5, 8x6 instance.
module tb_conv_out_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [19:0] in_data = '0;
    logic        out_valid, out_ready, out_sof, out_eol, out_eof, frame_done;
    logic [7:0]  out_data;
    logic        man_rdy = 1'b1, rand_mode = 1'b0, rnd_rdy = 1'b1;

    logic        in_valid5 = 1'b0, in_ready5, out_valid5, out_sof5, out_eol5, out_eof5, frame_done5;
    logic [19:0] in_data5 = '0;
    logic [7:0]  out_data5;

    int n_checks = 0, n_errors = 0;
    int fd_cnt = 0, fd_bad = 0, fd5_cnt = 0;
    logic eof_xfer_prev = 1'b0;
    logic [10:0] got_q[$], got5_q[$], exp_q[$];
    int din[300];

    always #5 clk = ~clk;
    assign out_ready = rand_mode ? rnd_rdy : man_rdy;

    conv_out_collector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done)
    );

    conv_out_collector #(.KERNEL(5), .ROW_SIZE(8), .IMG_ROWS(6)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(1'b1), .out_data(out_data5), .out_sof(out_sof5),
        .out_eol(out_eol5), .out_eof(out_eof5), .frame_done(frame_done5)
    );

    initial forever begin
        @(posedge clk);
        #1;
        rnd_rdy = ($urandom_range(0, 99) < 30);
    end

    // Monitor samples on the falling edge; inputs change just after the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            eof_xfer_prev = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (frame_done !== eof_xfer_prev) fd_bad++;
            eof_xfer_prev = out_valid && out_ready && out_eof;
            if (out_valid && out_ready) got_q.push_back({out_data, out_sof, out_eol, out_eof});
            if (frame_done5) fd5_cnt++;
            if (out_valid5) got5_q.push_back({out_data5, out_sof5, out_eol5, out_eof5});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rq(input int d);
        int v;
        v = d >>> 4;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    task automatic build_exp(input int rs, input int rows, input int k, input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++) begin
            for (int n = 0; n < rs * rows; n++) begin
                int c, r;
                logic s, l, e;
                c = n % rs;
                r = n / rs;
                if (c >= k - 1 && r >= k - 1) begin
                    s = (c == k - 1) && (r == k - 1);
                    l = (c == rs - 1);
                    e = l && (r == rows - 1);
                    exp_q.push_back({rq(din[f * rs * rows + n]), s, l, e});
                end
            end
        end
    endtask

    task automatic send(input int d, input bit idle);
        int waited = 0;
        while (idle && $urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d[19:0];
        @(negedge clk);
        while (!in_ready && waited < 500) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send5(input int d);
        in_valid5 = 1'b1;
        in_data5  = d[19:0];
        @(negedge clk);
        if (!in_ready5) check("in_ready5", 32'(in_ready5), 32'd1);
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 3000 && got_q.size() < n; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name, input logic [10:0] act[$]);
        check({name, "_count"}, 32'(act.size()), 32'(exp_q.size()));
        for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_beat%0d", name, i), 32'(act[i]), 32'(exp_q[i]));
        end
        $display("frame %s: %0d beats observed, %0d expected", name, act.size(), exp_q.size());
    endtask

    task automatic clear_mon();
        got_q.delete();
        fd_cnt = 0;
        fd_bad = 0;
    endtask

    initial begin
        int s_cnt, l_cnt, e_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        // 1: ramp, values equal to input index
        for (int n = 0; n < 100; n++) din[n] = n << 4;
        build_exp(10, 10, 3, 1);
        clear_mon();
        for (int n = 0; n < 100; n++) send(din[n], 1'b0);
        wait_beats(64);
        compare("ramp", got_q);
        check("ramp_frame_done", 32'(fd_cnt), 32'd1);
        check("ramp_fd_timing", 32'(fd_bad), 32'd0);

        // 2: requant corners at kept positions 22..25
        din[22] = -5;
        din[23] = 300 << 4;
        din[24] = 200 << 4;
        din[25] = -1;
        build_exp(10, 10, 3, 1);
        clear_mon();
        for (int n = 0; n < 100; n++) begin
            send(din[n], 1'b0);
            if (n == 22) begin
                check("lat_out_valid", 32'(out_valid), 32'd1);
                check("lat_out_data", 32'(out_data), 32'd0);
                check("lat_out_sof", 32'(out_sof), 32'd1);
            end
        end
        wait_beats(64);
        compare("requant", got_q);
        check("rq_sat_hi", 32'(got_q[1][10:3]), 32'd255);
        check("rq_mid", 32'(got_q[2][10:3]), 32'd200);

        // 3: sink stalled, FIFO fills after 22..25
        for (int n = 0; n < 100; n++) din[n] = n << 4;
        build_exp(10, 10, 3, 1);
        clear_mon();
        man_rdy = 1'b0;
        for (int n = 0; n < 26; n++) send(din[n], 1'b0);
        in_valid = 1'b1;
        in_data  = 20'(26 << 4);
        repeat (5) @(posedge clk);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_data", 32'(out_data), 32'd22);
        check("stall_out_sof", 32'(out_sof), 32'd1);
        check("stall_no_beats", 32'(got_q.size()), 32'd0);
        man_rdy = 1'b1;
        for (int n = 26; n < 100; n++) send(din[n], 1'b0);
        wait_beats(64);
        compare("backpressure", got_q);

        // 4: random valid/ready, three back-to-back frames
        for (int n = 0; n < 300; n++) din[n] = int'($urandom_range(0, 8000)) - 2000;
        build_exp(10, 10, 3, 3);
        clear_mon();
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) send(din[n], 1'b1);
        wait_beats(192);
        rand_mode = 1'b0;
        compare("random", got_q);
        s_cnt = 0; l_cnt = 0; e_cnt = 0;
        foreach (got_q[i]) begin
            s_cnt += int'(got_q[i][2]);
            l_cnt += int'(got_q[i][1]);
            e_cnt += int'(got_q[i][0]);
        end
        check("random_sof", 32'(s_cnt), 32'd3);
        check("random_eol", 32'(l_cnt), 32'd24);
        check("random_eof", 32'(e_cnt), 32'd3);
        check("random_frame_done", 32'(fd_cnt), 32'd3);
        check("random_fd_timing", 32'(fd_bad), 32'd0);

        // 5: reset mid-frame with FIFO occupied
        for (int n = 0; n < 100; n++) din[n] = n << 4;
        build_exp(10, 10, 3, 1);
        for (int n = 0; n < 55; n++) send(din[n], 1'b0);
        man_rdy = 1'b0;
        send(din[55], 1'b0);
        send(din[56], 1'b0);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 20'(57 << 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        man_rdy = 1'b1;
        clear_mon();
        for (int n = 0; n < 100; n++) send(din[n], 1'b0);
        wait_beats(64);
        compare("after_reset", got_q);
        check("after_reset_sof", 32'(got_q.size() > 0 ? got_q[0][2] : 1'b0), 32'd1);

        // 6: K=5 on an 8x6 image
        for (int n = 0; n < 48; n++) din[n] = n << 4;
        build_exp(8, 6, 5, 1);
        got5_q.delete();
        fd5_cnt = 0;
        for (int n = 0; n < 48; n++) send5(din[n]);
        repeat (4) @(posedge clk);
        #1;
        compare("k5", got5_q);
        check("k5_first", 32'(got5_q.size() > 0 ? got5_q[0][10:3] : 8'd0), 32'd36);
        check("k5_frame_done", 32'(fd5_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
